pcode_sequencer: RTL

PCODE_SEQUENCER -- requirements
Module: pcode_sequencer

---
 rtl/pcode_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pcode_sequencer.sv
// P-code chip/repeat/message address sequencer with pps-aligned start and frame
// accounting. Addresses are d0 to the code ROM; enables align with d1 ROM data.
module pcode_sequencer #(
  parameter int unsigned PCODE_LEN     = 40920,
  parameter int unsigned PCODE_REPEATS = 10,
  parameter int unsigned MESSAGE_LEN   = 120
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           continuous,
  input  logic                           pps_align,
  input  logic                           pps,
  input  logic                           dac_valid,
  input  logic                           msg_i_en_cfg,
  input  logic                           msg_q_en_cfg,
  output logic [$clog2(PCODE_LEN)-1:0]   pcode_addr,
  output logic [$clog2(MESSAGE_LEN)-1:0] msg_addr,
  output logic                           message_i_enable,
  output logic                           message_q_enable,
  output logic                           frame_start,
  output logic                           frame_done,
  output logic [15:0]                    frame_count,
  output logic                           busy
);

  localparam int unsigned CW = $clog2(PCODE_LEN);
  localparam int unsigned MW = $clog2(MESSAGE_LEN);
  localparam int unsigned RW = (PCODE_REPEATS > 1) ? $clog2(PCODE_REPEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] rep_cnt;
  logic          pps_d;
  logic          active_d1;

  logic run_adv;
  logic pps_rise;
  logic chip_last;
  logic rep_last;
  logic msg_last;
  logic at_origin;

  assign run_adv   = (state == RUN) && dac_valid;
  assign pps_rise  = pps && !pps_d;
  assign chip_last = (pcode_addr == CW'(PCODE_LEN - 1));
  assign rep_last  = (rep_cnt == RW'(PCODE_REPEATS - 1));
  assign msg_last  = (msg_addr == MW'(MESSAGE_LEN - 1));
  assign at_origin = (pcode_addr == '0) && (rep_cnt == '0) && (msg_addr == '0);

  // Enables are a gated copy of the d1 activity flag so they line up with ROM data.
  assign message_i_enable = msg_i_en_cfg && active_d1;
  assign message_q_enable = msg_q_en_cfg && active_d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pcode_addr  <= '0;
      rep_cnt     <= '0;
      msg_addr    <= '0;
      frame_count <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      pps_d       <= 1'b0;
      active_d1   <= 1'b0;
    end else begin
      pps_d       <= pps;
      active_d1   <= run_adv;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (stop) begin
        // Abort wins over start and over a coincident frame end.
        state      <= IDLE;
        busy       <= 1'b0;
        pcode_addr <= '0;
        rep_cnt    <= '0;
        msg_addr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= ARMED;
              busy  <= 1'b1;
            end
          end
          ARMED: begin
            if (!pps_align || pps_rise) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (dac_valid) begin
              frame_start <= at_origin;
              if (!chip_last) begin
                pcode_addr <= pcode_addr + CW'(1);
              end else begin
                pcode_addr <= '0;
                if (!rep_last) begin
                  rep_cnt <= rep_cnt + RW'(1);
                end else begin
                  rep_cnt <= '0;
                  if (!msg_last) begin
                    msg_addr <= msg_addr + MW'(1);
                  end else begin
                    msg_addr    <= '0;
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                    if (!continuous) begin
                      state <= IDLE;
                      busy  <= 1'b0;
                    end
                  end
                end
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
